alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Sequential front/back end for the combinational 8-bit ALU (alu_8bit). Sits directly around it.
- Accepts operation commands over a valid/ready handshake and reads operands from an internal 8x8 register file (or an immediate).
- Drives the ALU's A, B and opcode inputs, then writes the ALU result back to a destination register and latches the four ALU flags.

Parameters:
- NREGS, 8, number of 8-bit registers; must be a power of 2.
- AW, 3, register address width, equal to log2(NREGS).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high at a clk edge.
- cmd_opcode  in  4  ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SLL, 7 SRL, 8 SLA, 9 SRA, A INC, B DEC, C EQ, D LT, E GT, F PASS.
- cmd_rd  in  AW  destination register.
- cmd_rs1  in  AW  source register for A.
- cmd_rs2  in  AW  source register for B.
- cmd_imm_en  in  1  when 1, B comes from cmd_imm instead of rs2.
- cmd_imm  in  8  immediate operand.
- wr_en  in  1  host register write.
- wr_addr  in  AW  host write address.
- wr_data  in  8  host write data.
- rd_addr  in  AW  debug read address.
- rd_data  out  8  combinational read of regfile[rd_addr].
- alu_a  out  8  to ALU A, registered.
- alu_b  out  8  to ALU B, registered.
- alu_opcode  out  4  to ALU opcode, registered.
- alu_result  in  8  from ALU.
- alu_zero, alu_carry, alu_overflow, alu_sign  in  1 each  from ALU.
- rsp_valid  out  1  one-cycle pulse when writeback completes.
- rsp_data  out  8  result written, valid with rsp_valid.
- flags  out  4  {Z,C,V,N}, latched at writeback.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - All registers are set to 00; flags = 0000.
  - alu_a, alu_b and rsp_data = 00; alu_opcode = F (PASS).
  - rsp_valid = 0; busy = 0.
- FSM has three states: IDLE -> ISSUE -> WB -> IDLE.
- IDLE:
  - cmd_ready = !wr_en. A host write has priority, so no command is accepted in a cycle where wr_en is high.
  - On accept:
    - alu_a <= reg[rs1].
    - alu_b <= cmd_imm if cmd_imm_en, else reg[rs2].
    - alu_opcode <= cmd_opcode; rd is latched.
    - Next state is ISSUE.
- ISSUE:
  - One cycle for ALU combinational settle; operands are held.
  - Next state is WB.
- WB:
  - reg[rd] <= alu_result.
  - flags <= {alu_zero, alu_carry, alu_overflow, alu_sign}.
  - rsp_valid = 1 for this cycle; rsp_data = alu_result.
  - Next state is IDLE.
- Latency: accept at edge N; rsp_valid is high during cycle N+2; the next accept can be at edge N+3. Throughput is 1 op per 3 cycles.
- alu_a, alu_b and alu_opcode hold their last values in IDLE. Do not return them to PASS.
- wr_en outside IDLE is ignored: no write, no error.
- Operand read before writeback: operands are sampled at accept, so a previous op's writeback is always visible. There is no hazard, because accept cannot overlap WB.
- rd equal to rs1 or rs2 is legal; the old value is used as the operand.
- Compare ops (C, D, E) write FF or 00 to rd like any other op.
- rd_data is a purely combinational read. It shows a WB write from the edge that performs it onward.
- Reset asserted mid-operation aborts the op: no writeback, no rsp_valid, and all state returns to reset values immediately.

Optional Feature:
- Macro: ALU_STICKY_OVF_EN.
- When defined:
  - Adds output sticky_ovf (1 bit) and input sticky_clr (1 bit).
  - sticky_ovf is set in WB when alu_overflow = 1 and stays high until sticky_clr or reset.
  - If sticky_clr and a setting WB occur in the same cycle, the set wins.
- When undefined: neither port exists and there is no extra state.

Test Plan:
- Reset then idle: all regs 00, flags 0000, alu_opcode F, cmd_ready 1, busy 0.
- Overflow add: wr R1=7F, R2=01; cmd ADD rd=3 rs1=1 rs2=2 -> rsp_valid 2 cycles after accept, R3=80, flags Z0 C1? No: C0, V1, N1, i.e. flags=0011.
- Immediate zero result: R1=05; cmd SUB rd=4 rs1=1, imm_en=1, imm=05 -> R4=00, flags=1000.
- Handshake: cmd_valid held high for 2 back-to-back ops -> cmd_ready low in ISSUE/WB, 2nd accept 3 cycles after 1st; concurrent wr_en in IDLE -> cmd_ready 0 and write lands.
- Reset mid-op: rst_n low during ISSUE of INC R5 (R5=10) -> R5 stays 00 after reset, no rsp_valid.
- With ALU_STICKY_OVF_EN: DEC on 80 sets sticky_ovf; following ADD 01+01 leaves it 1; sticky_clr clears it to 0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Sequencer around the combinational 8-bit ALU: a command handshake, a register
// file, registered ALU operands and result writeback. Optional sticky overflow: ALU_STICKY_OVF_EN.
module alu_op_sequencer #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_opcode,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic          cmd_imm_en,
  input  logic [7:0]    cmd_imm,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [3:0]    alu_opcode,
  input  logic [7:0]    alu_result,
  input  logic          alu_zero,
  input  logic          alu_carry,
  input  logic          alu_overflow,
  input  logic          alu_sign,
  output logic          rsp_valid,
  output logic [7:0]    rsp_data,
  output logic [3:0]    flags,
`ifdef ALU_STICKY_OVF_EN
  input  logic          sticky_clr,
  output logic          sticky_ovf,
`endif
  output logic          busy
);

  localparam int unsigned DW = 8;
  localparam logic [3:0]  OP_PASS = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WB
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          accept_c;
  logic          host_wr_c;
  logic          wb_c;
  logic [DW-1:0] regs [NREGS];
  logic [AW-1:0] rd_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and handshake; a host write blocks command acceptance
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    accept_c   = 1'b0;
    host_wr_c  = 1'b0;
    wb_c       = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = !wr_en;
        host_wr_c = wr_en;
        if (cmd_valid && !wr_en) begin
          accept_c   = 1'b1;
          next_state = S_ISSUE;
        end
      end
      S_ISSUE: next_state = S_WB;
      S_WB: begin
        wb_c       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Operand capture, register file, writeback and response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= OP_PASS;
      rd_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      flags      <= '0;
      busy       <= 1'b0;
    end else begin
      rsp_valid <= wb_c;
      busy      <= (next_state != S_IDLE);
      if (accept_c) begin
        alu_a      <= regs[cmd_rs1];
        alu_b      <= cmd_imm_en ? cmd_imm : regs[cmd_rs2];
        alu_opcode <= cmd_opcode;
        rd_q       <= cmd_rd;
      end
      if (host_wr_c) begin
        regs[wr_addr] <= wr_data;
      end
      if (wb_c) begin
        regs[rd_q] <= alu_result;
        rsp_data   <= alu_result;
        flags      <= {alu_zero, alu_carry, alu_overflow, alu_sign};
      end
    end
  end

  assign rd_data = regs[rd_addr];

`ifdef ALU_STICKY_OVF_EN
  // Sticky overflow: a setting writeback wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
    end else if (wb_c && alu_overflow) begin
      sticky_ovf <= 1'b1;
    end else if (sticky_clr) begin
      sticky_ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a behavioural ALU closes the loop and a
// scoreboard queue holds the expected writeback of every accepted command.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_opcode = '0;
  logic [2:0] cmd_rd = '0;
  logic [2:0] cmd_rs1 = '0;
  logic [2:0] cmd_rs2 = '0;
  logic       cmd_imm_en = 1'b0;
  logic [7:0] cmd_imm = '0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [2:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_opcode;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       alu_carry;
  logic       alu_overflow;
  logic       alu_sign;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [3:0] flags;
  logic       busy;
`ifdef ALU_STICKY_OVF_EN
  logic       sticky_clr = 1'b0;
  logic       sticky_ovf;
`endif

  typedef struct {
    logic [7:0] data;
    logic [3:0] flg;
    logic [2:0] rd;
  } exp_t;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] mregs [8];
  bit         mstick = 1'b0;
  exp_t       sb [$];

  alu_op_sequencer #(.NREGS(8), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .alu_sign(alu_sign),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .flags(flags),
`ifdef ALU_STICKY_OVF_EN
    .sticky_clr(sticky_clr), .sticky_ovf(sticky_ovf),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural ALU: returns {Z,C,V,N,result}; carry on SUB/DEC means borrow
  function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    logic [7:0] r;
    logic       c;
    logic       v;
    t = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'h0: begin t = {1'b0, a} + {1'b0, b}; r = t[7:0]; c = t[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'h1: begin t = {1'b0, a} - {1'b0, b}; r = t[7:0]; c = t[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = ~a;
      4'h6: begin r = {a[6:0], 1'b0}; c = a[7]; end
      4'h7: begin r = {1'b0, a[7:1]}; c = a[0]; end
      4'h8: begin r = {a[6:0], 1'b0}; c = a[7]; v = a[7] ^ a[6]; end
      4'h9: begin r = {a[7], a[7:1]}; c = a[0]; end
      4'hA: begin t = {1'b0, a} + 9'd1; r = t[7:0]; c = t[8]; v = (a == 8'h7F); end
      4'hB: begin r = a - 8'd1; c = (a == 8'h00); v = (a == 8'h80); end
      4'hC: r = (a == b) ? 8'hFF : 8'h00;
      4'hD: r = (a < b) ? 8'hFF : 8'h00;
      4'hE: r = (a > b) ? 8'hFF : 8'h00;
      default: r = a;
    endcase
    return {(r == 8'h00), c, v, r[7], r};
  endfunction

  always_comb {alu_zero, alu_carry, alu_overflow, alu_sign, alu_result} = alu_f(alu_opcode, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    mregs[a] = d;
  endtask

  // Present a command, wait (bounded) for acceptance and push its expected writeback
  task automatic send_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic ie, input logic [7:0] imm,
                          input bit hold, output int acc);
    int         w;
    exp_t       e;
    logic [11:0] m;
    logic [7:0] b;
    cmd_opcode = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_imm_en = ie; cmd_imm = imm; cmd_valid = 1'b1;
    w = 0; acc = -1;
    #1;
    while (!cmd_ready && w < 10) begin
      @(negedge clk); #1; w++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'(cmd_ready), 32'd1);
    end else begin
      b = ie ? imm : mregs[rs2];
      m = alu_f(op, mregs[rs1], b);
      e.data = m[7:0]; e.flg = m[11:8]; e.rd = rd;
      sb.push_back(e);
      @(posedge clk); #1;
      acc = cyc;
      if (!hold) cmd_valid = 1'b0;
    end
  endtask

  // Wait (bounded) for rsp_valid, then pop and compare against the scoreboard
  task automatic wait_rsp();
    int   lat;
    exp_t e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("busy_in_issue", 32'(busy), 32'd1);
        chk("ready_in_issue", 32'(cmd_ready), 32'd0);
      end
    end while (!rsp_valid && lat < 8);
    chk("rsp_latency", 32'(lat), 32'd3);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("rsp_data", 32'(rsp_data), 32'(e.data));
      chk("flags", 32'(flags), 32'(e.flg));
      rd_addr = e.rd;
      #1;
      chk("rd_writeback", 32'(rd_data), 32'(e.data));
      chk("busy_after_wb", 32'(busy), 32'd0);
      mregs[e.rd] = e.data;
      mstick = mstick | e.flg[1];
`ifdef ALU_STICKY_OVF_EN
      chk("sticky_track", 32'(sticky_ovf), 32'(mstick));
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  a0;
    int  a1;
    bit  seen;
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk("reset_reg", 32'(rd_data), 32'h00);
    end
    chk("reset_flags", 32'(flags), 32'h0);
    chk("reset_opcode", 32'(alu_opcode), 32'hF);
    chk("reset_ready", 32'(cmd_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'h00);
    chk("reset_alu_a", 32'(alu_a), 32'h00);
    chk("reset_alu_b", 32'(alu_b), 32'h00);

    // Overflowing ADD 7F + 01
    host_write(3'd1, 8'h7F);
    host_write(3'd2, 8'h01);
    send_cmd(4'h0, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 1'b0, a0);
    wait_rsp();
    chk("add_ovf_result", 32'(rsp_data), 32'h80);
    chk("add_ovf_flags", 32'(flags), 32'b0011);

    // Immediate SUB giving zero; operands hold in IDLE
    host_write(3'd1, 8'h05);
    send_cmd(4'h1, 3'd4, 3'd1, 3'd0, 1'b1, 8'h05, 1'b0, a0);
    wait_rsp();
    chk("sub_zero_flags", 32'(flags), 32'b1000);
    chk("opcode_hold", 32'(alu_opcode), 32'h1);
    chk("alu_b_imm_hold", 32'(alu_b), 32'h05);

    // rd equal to both sources uses the old value
    send_cmd(4'h0, 3'd1, 3'd1, 3'd1, 1'b0, 8'h00, 1'b0, a0);
    wait_rsp();
    chk("rd_eq_rs_result", 32'(rsp_data), 32'h0A);

    // Back-to-back with cmd_valid held high
    send_cmd(4'h2, 3'd2, 3'd3, 3'd1, 1'b0, 8'h00, 1'b1, a0);
    wait_rsp();
    send_cmd(4'hC, 3'd6, 3'd3, 3'd3, 1'b0, 8'h00, 1'b0, a1);
    chk("b2b_accept_spacing", 32'(a1 - a0), 32'd3);
    wait_rsp();
    chk("eq_true_result", 32'(rsp_data), 32'hFF);

    // Host write has priority over a concurrent command
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'hAA;
    cmd_opcode = 4'hF; cmd_rd = 3'd0; cmd_rs1 = 3'd6; cmd_imm_en = 1'b0; cmd_valid = 1'b1;
    #1;
    chk("ready_during_wr", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    wr_en = 1'b0; cmd_valid = 1'b0;
    mregs[6] = 8'hAA;
    rd_addr = 3'd6;
    #1;
    chk("host_write_lands", 32'(rd_data), 32'hAA);
    chk("no_accept_on_wr", 32'(busy), 32'd0);
    send_cmd(4'hF, 3'd0, 3'd6, 3'd0, 1'b0, 8'h00, 1'b0, a0);
    wait_rsp();

    // Sweep every opcode with random operands
    for (int op = 0; op < 16; op++) begin
      host_write(3'd1, 8'($urandom));
      host_write(3'd2, 8'($urandom));
      send_cmd(4'(op), 3'd7, 3'd1, 3'd2, 1'((op >> 1) & 1), 8'($urandom), 1'b0, a0);
      wait_rsp();
    end

    // Host write outside IDLE is dropped
    send_cmd(4'hF, 3'd5, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, a0);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h55;
    wait_rsp();
    wr_en = 1'b0;
    rd_addr = 3'd4;
    #1;
    chk("busy_write_ignored", 32'(rd_data), 32'(mregs[4]));

    // Reset during ISSUE aborts the op
    host_write(3'd5, 8'h10);
    send_cmd(4'hA, 3'd5, 3'd5, 3'd0, 1'b0, 8'h00, 1'b0, a0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midop_busy", 32'(busy), 32'd0);
    chk("midop_opcode", 32'(alu_opcode), 32'hF);
    chk("midop_alu_a", 32'(alu_a), 32'h00);
    chk("midop_flags", 32'(flags), 32'h0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("midop_no_rsp", 32'(seen), 32'd0);
    rd_addr = 3'd5;
    #1;
    chk("midop_r5_cleared", 32'(rd_data), 32'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    sb.delete();
    mstick = 1'b0;
    @(negedge clk); #1;
    chk("post_reset_ready", 32'(cmd_ready), 32'd1);
    send_cmd(4'hA, 3'd5, 3'd5, 3'd0, 1'b0, 8'h00, 1'b0, a0);
    wait_rsp();
    chk("post_reset_inc", 32'(rsp_data), 32'h01);

`ifdef ALU_STICKY_OVF_EN
    // Sticky overflow set, hold and clear
    host_write(3'd7, 8'h80);
    send_cmd(4'hB, 3'd7, 3'd7, 3'd0, 1'b0, 8'h00, 1'b0, a0);
    wait_rsp();
    chk("sticky_set_dec80", 32'(sticky_ovf), 32'd1);
    host_write(3'd1, 8'h01);
    send_cmd(4'h0, 3'd2, 3'd1, 3'd1, 1'b0, 8'h00, 1'b0, a0);
    wait_rsp();
    chk("sticky_hold", 32'(sticky_ovf), 32'd1);
    @(negedge clk);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    mstick = 1'b0;
    #1;
    chk("sticky_clear", 32'(sticky_ovf), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
